// File: rtl/deserialiser_frame_unit.sv
// Serial-to-parallel frame deserialiser: WORD_W-bit words, NUM_WORDS per frame, valid/ack hold with sticky overrun.
// Frame valid on the edge sampling the last bit; no backpressure (overwrite sets OVERRUN); DESER_MSB_FIRST_EN selects MSB-first words.
module deserialiser_frame_unit #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          READY,
   input  logic                          SERIAL_IN,
   input  logic                          FRAME_ACK,
   output logic [WORD_W*NUM_WORDS-1:0]   PAR_OUT,
   output logic                          FRAME_VALID,
   output logic                          OVERRUN,
   output logic                          BUSY,
   output logic [$clog2(WORD_W)-1:0]     BIT_COUNT,
   output logic [$clog2(NUM_WORDS)-1:0]  WORD_COUNT
);

   localparam int FRAME_W = WORD_W * NUM_WORDS;
   localparam int BW      = $clog2(WORD_W);
   localparam int WW      = $clog2(NUM_WORDS);
   localparam int IW      = $clog2(FRAME_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_nxt;
   logic [FRAME_W-1:0]   asm_q, asm_nxt;
   logic [FRAME_W-1:0]   par_q, par_nxt;
   logic [BW-1:0]        bit_q, bit_nxt;
   logic [WW-1:0]        word_q, word_nxt;
   logic                 fv_q, fv_nxt;
   logic                 ov_q, ov_nxt;
   logic                 busy_q, busy_nxt;
   logic                 frame_done;
   logic [BW-1:0]        bit_pos;
   logic [IW-1:0]        bit_idx;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         asm_q   <= '0;
         par_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         fv_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         asm_q   <= asm_nxt;
         par_q   <= par_nxt;
         bit_q   <= bit_nxt;
         word_q  <= word_nxt;
         fv_q    <= fv_nxt;
         ov_q    <= ov_nxt;
         busy_q  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      asm_nxt    = asm_q;
      par_nxt    = par_q;
      bit_nxt    = bit_q;
      word_nxt   = word_q;
      fv_nxt     = fv_q;
      ov_nxt     = ov_q;
      frame_done = 1'b0;
`ifdef DESER_MSB_FIRST_EN
      bit_pos    = BW'(WORD_W - 1) - bit_q;
`else
      bit_pos    = bit_q;
`endif
      bit_idx    = IW'(word_q) * IW'(WORD_W) + IW'(bit_pos);

      if (FRAME_ACK)
         fv_nxt = 1'b0;

      if (READY) begin
         state_nxt        = SHIFT;
         asm_nxt[bit_idx] = SERIAL_IN;
         if (bit_q == BW'(WORD_W - 1)) begin
            bit_nxt = '0;
            if (word_q == WW'(NUM_WORDS - 1)) begin
               word_nxt   = '0;
               frame_done = 1'b1;
            end else begin
               word_nxt = word_q + WW'(1);
            end
         end else begin
            bit_nxt = bit_q + BW'(1);
         end
         // Completion wins over a same-edge ack; overrun only if the held frame was never taken.
         if (frame_done) begin
            par_nxt = asm_nxt;
            asm_nxt = '0;
            fv_nxt  = 1'b1;
            if (fv_q && !FRAME_ACK)
               ov_nxt = 1'b1;
         end
      end else begin
         state_nxt = IDLE;
         asm_nxt   = '0;
         bit_nxt   = '0;
         word_nxt  = '0;
      end

      busy_nxt = (state_nxt == SHIFT) && ((bit_nxt != '0) || (word_nxt != '0));
   end

   assign PAR_OUT     = par_q;
   assign FRAME_VALID = fv_q;
   assign OVERRUN     = ov_q;
   assign BUSY        = busy_q;
   assign BIT_COUNT   = bit_q;
   assign WORD_COUNT  = word_q;

endmodule

// File: tb/tb_deserialiser_frame_unit.sv
// Bench for deserialiser_frame_unit at WORD_W=8, NUM_WORDS=4; frames are scoreboarded at stimulus time and checked at completion.
module tb_deserialiser_frame_unit;

   localparam int WORD_W    = 8;
   localparam int NUM_WORDS = 4;
   localparam int FRAME_W   = WORD_W * NUM_WORDS;

   logic               CLK = 1'b0;
   logic               RESET = 1'b1;
   logic               READY = 1'b0;
   logic               SERIAL_IN = 1'b0;
   logic               FRAME_ACK = 1'b0;
   logic [FRAME_W-1:0] PAR_OUT;
   logic               FRAME_VALID;
   logic               OVERRUN;
   logic               BUSY;
   logic [2:0]         BIT_COUNT;
   logic [1:0]         WORD_COUNT;

   int n_cmp = 0;
   int n_err = 0;
   logic [FRAME_W-1:0] exp_q[$];

   deserialiser_frame_unit #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
      .CLK(CLK), .RESET(RESET), .READY(READY), .SERIAL_IN(SERIAL_IN),
      .FRAME_ACK(FRAME_ACK), .PAR_OUT(PAR_OUT), .FRAME_VALID(FRAME_VALID),
      .OVERRUN(OVERRUN), .BUSY(BUSY), .BIT_COUNT(BIT_COUNT), .WORD_COUNT(WORD_COUNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drive one bit per edge; sample order follows the build's word bit order.
   task automatic send_frame(input logic [FRAME_W-1:0] f, input bit ack_last, input string tag);
      logic [FRAME_W-1:0] e;
      exp_q.push_back(f);
      for (int i = 0; i < FRAME_W; i++) begin
         int j, k;
         j = i / WORD_W;
         k = i % WORD_W;
         READY = 1'b1;
`ifdef DESER_MSB_FIRST_EN
         SERIAL_IN = f[j*WORD_W + WORD_W-1-k];
`else
         SERIAL_IN = f[j*WORD_W + k];
`endif
         FRAME_ACK = ack_last && (i == FRAME_W-1);
         tick();
      end
      FRAME_ACK = 1'b0;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_par"}, PAR_OUT, e);
         chk({tag, "_valid"}, FRAME_VALID, 1);
      end
   endtask

   task automatic send_bits(input int n, input logic v);
      for (int i = 0; i < n; i++) begin
         READY = 1'b1;
         SERIAL_IN = v;
         tick();
      end
   endtask

   task automatic idle_ack(input logic ack);
      READY = 1'b0;
      SERIAL_IN = 1'b0;
      FRAME_ACK = ack;
      tick();
      FRAME_ACK = 1'b0;
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      chk("rst_par", PAR_OUT, 0);
      chk("rst_valid", FRAME_VALID, 0);
      chk("rst_ovr", OVERRUN, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_bitcnt", BIT_COUNT, 0);
      chk("rst_wordcnt", WORD_COUNT, 0);
      RESET = 1'b0;
      tick();

      // Counters part-way through a frame, then completion and ack
      exp_q.push_back(32'hF00F3CA5);
      for (int i = 0; i < 10; i++) begin
         READY = 1'b1;
         SERIAL_IN = 1'b0;
         tick();
      end
      chk("mid_bitcnt", BIT_COUNT, 2);
      chk("mid_wordcnt", WORD_COUNT, 1);
      chk("mid_busy", BUSY, 1);
      idle_ack(1'b0);
      chk("abort0_busy", BUSY, 0);
      chk("abort0_bitcnt", BIT_COUNT, 0);
      void'(exp_q.pop_front());
      chk("ack_idle_ignored", FRAME_VALID, 0);

      send_frame(32'hF00F3CA5, 1'b0, "single");
      chk("single_bitcnt", BIT_COUNT, 0);
      chk("single_wordcnt", WORD_COUNT, 0);
      chk("single_busy", BUSY, 0);
      chk("single_ovr", OVERRUN, 0);
      idle_ack(1'b1);
      chk("single_ack_valid", FRAME_VALID, 0);
      chk("single_ack_par", PAR_OUT, 32'hF00F3CA5);

      // Abort after 12 bits of ones, then a clean frame
      send_bits(12, 1'b1);
      chk("abort_busy_pre", BUSY, 1);
      idle_ack(1'b0);
      chk("abort_busy", BUSY, 0);
      chk("abort_wordcnt", WORD_COUNT, 0);
      chk("abort_par_kept", PAR_OUT, 32'hF00F3CA5);
      chk("abort_valid_kept", FRAME_VALID, 0);
      send_frame(32'h11223344, 1'b0, "after_abort");
      idle_ack(1'b1);

      // Back-to-back frames without ack
      send_frame(32'hDEADBEEF, 1'b0, "ovr_f1");
      chk("ovr_f1_ovr", OVERRUN, 0);
      send_frame(32'hCAFEF00D, 1'b0, "ovr_f2");
      chk("ovr_f2_ovr", OVERRUN, 1);
      idle_ack(1'b1);
      chk("ovr_ack_valid", FRAME_VALID, 0);
      for (int i = 0; i < 3; i++) idle_ack(1'b0);
      chk("ovr_sticky", OVERRUN, 1);

      // Asynchronous reset mid-stream
      send_bits(10, 1'b1);
      #2 RESET = 1'b1;
      #1;
      chk("arst_par", PAR_OUT, 0);
      chk("arst_ovr", OVERRUN, 0);
      chk("arst_bitcnt", BIT_COUNT, 0);
      chk("arst_wordcnt", WORD_COUNT, 0);
      chk("arst_busy", BUSY, 0);
      READY = 1'b0;
      tick();
      RESET = 1'b0;
      tick();
      send_frame(32'h01020304, 1'b0, "post_rst");
      idle_ack(1'b1);

      // Ack coincident with second completion
      send_frame(32'hDEADBEEF, 1'b0, "coin_f1");
      send_frame(32'hCAFEF00D, 1'b1, "coin_f2");
      chk("coin_ovr", OVERRUN, 0);
      idle_ack(1'b0);
      chk("coin_valid_hold", FRAME_VALID, 1);
      idle_ack(1'b1);
      chk("coin_ack_valid", FRAME_VALID, 0);

      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/deserialiser_frame_unit.md
# deserialiser_frame_unit

Parametrised serial-to-parallel frame deserialiser for the receive path. It shifts SERIAL_IN into WORD_W-bit words and gathers NUM_WORDS words into one frame. The completed frame is presented on a flattened parallel bus with a valid/acknowledge handshake and a sticky overrun flag. It sits between the sampler/CDR output and the receive-side frame consumer.

## Interface
Parameters:
- WORD_W, 32, bits per word; legal range 2 or more.
- NUM_WORDS, 8, words per frame; legal range 2 or more.

Ports:
- CLK  input  1  single clock; all sampling on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- READY  input  1  serial data valid; a bit is sampled on every CLK edge while this is 1.
- SERIAL_IN  input  1  serial data bit.
- FRAME_ACK  input  1  consumer acknowledge for the held frame.
- PAR_OUT  output  WORD_W*NUM_WORDS  completed frame; word j sits at bits [j*WORD_W +: WORD_W].
- FRAME_VALID  output  1  a completed, unacknowledged frame is on PAR_OUT.
- OVERRUN  output  1  sticky; a frame was overwritten before it was acknowledged.
- BUSY  output  1  a partial frame is in progress.
- BIT_COUNT  output  $clog2(WORD_W)  bit index of the next sample within the current word.
- WORD_COUNT  output  $clog2(NUM_WORDS)  index of the word currently being assembled.

## Operation
- States:
  - IDLE: no partial frame.
  - SHIFT: partial frame in progress.
- IDLE to SHIFT on the first edge with READY=1.
- SHIFT to IDLE on an edge with READY=0, or on the edge that samples the final bit of the frame while READY=0 on the next edge.
- Bit order (default) is LSB-first: bit k of word j is the (j*WORD_W+k)-th sample of the frame.
- BIT_COUNT increments on each sample and wraps from WORD_W-1 to 0. On that wrap, WORD_COUNT increments.
- WORD_COUNT wraps from NUM_WORDS-1 to 0 at frame completion.
- The assembly register is separate from PAR_OUT. PAR_OUT changes only at frame completion.
- Frame completion happens on the edge sampling bit WORD_W-1 of word NUM_WORDS-1. On that edge:
  - PAR_OUT loads the assembled frame, including the bit sampled on that edge.
  - FRAME_VALID is set.
  - Counters return to 0.
- Back-to-back frames: if READY stays 1, the next frame's first bit is sampled on the very next edge, with no gap cycle.
- READY=0 mid-frame aborts the frame:
  - The partial frame is discarded.
  - The assembly register, BIT_COUNT and WORD_COUNT clear to 0.
  - PAR_OUT, FRAME_VALID and OVERRUN are unaffected.
- Handshake rules:
  - FRAME_VALID holds at 1 until an edge with FRAME_ACK=1. That edge clears it.
  - FRAME_ACK while FRAME_VALID=0 is ignored.
  - Completion with FRAME_VALID=1 and FRAME_ACK=0: PAR_OUT is overwritten, FRAME_VALID stays 1, OVERRUN is set.
  - Completion and FRAME_ACK on the same edge: the new frame loads, FRAME_VALID stays 1, OVERRUN is not set.
- OVERRUN clears only on RESET.
- BUSY=1 when in SHIFT with at least one bit of the current frame sampled; otherwise 0.

## Timing
- Reset values: PAR_OUT=0, FRAME_VALID=0, OVERRUN=0, BUSY=0, BIT_COUNT=0, WORD_COUNT=0. The assembly register is 0 and the state is IDLE.
- RESET asserted mid-frame clears all state immediately (asynchronously). The first sample after RESET deasserts starts a new frame at bit 0.
- Latency: FRAME_VALID rises on the same edge that samples the last bit. That is edge number WORD_W*NUM_WORDS counted from the first READY=1 edge of the frame.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Sustained throughput: one frame per WORD_W*NUM_WORDS cycles.

## Configuration
- DESER_MSB_FIRST_EN:
  - Defined: each word is received MSB-first; sample k of word j lands in bit WORD_W-1-k of that word. Word order within the frame is unchanged, with word 0 in the LSBs.
  - Undefined: LSB-first, as described in Operation.
  - Counters, handshake and timing are identical in both builds.

## Test plan
All scenarios use WORD_W=8, NUM_WORDS=4.
- Reset: assert RESET mid-stream -> all outputs 0 immediately. After release, the frame 0x01020304 is received intact.
- Single frame, LSB-first, words 0xA5, 0x3C, 0x0F, 0xF0 with READY held high -> on edge 32, FRAME_VALID=1 and PAR_OUT=0xF00F3CA5. FRAME_ACK one cycle later -> FRAME_VALID=0.
- Abort: READY low after 12 bits, then a full frame 0x11223344 -> PAR_OUT=0x11223344 with no contamination from the partial frame, and BUSY=0 during the READY-low cycle.
- Overrun: two back-to-back frames 0xDEADBEEF then 0xCAFEF00D with no ACK -> edge 32 gives VALID=1 with PAR_OUT=0xDEADBEEF. Edge 64 gives PAR_OUT=0xCAFEF00D and OVERRUN=1, which stays 1 until RESET.
- ACK coincident with completion at edge 64 of the back-to-back stream -> FRAME_VALID stays 1, PAR_OUT=0xCAFEF00D, OVERRUN=0.
- Build with DESER_MSB_FIRST_EN and send the words of 0xF00F3CA5 MSB-first -> PAR_OUT=0xF00F3CA5 on edge 32.
